// File: rtl/tdc_pkg.sv
// tdc_pkg: field widths, event-word layout offsets and word-width helper for the TDC readout path.
package tdc_pkg;
    localparam int COARSE_W = 4;
    localparam int FINE_W = 2;
    localparam int FINE_LSB = 0;
    localparam int COARSE_LSB = FINE_LSB + FINE_W;
    localparam int SEQ_LSB = COARSE_LSB + COARSE_W;
    function automatic int word_w(input int seq_w);
        return seq_w + COARSE_W + FINE_W + 1;
    endfunction
    function automatic int lost_lsb(input int seq_w);
        return SEQ_LSB + seq_w;
    endfunction
endpackage

// File: rtl/tdc_sync_fifo.sv
// tdc_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count.
module tdc_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 15,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt;
    logic do_pop, do_push;
    assign do_pop = pop & ~empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign level = cnt;
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/tdc_readout_buffer.sv
// tdc_readout_buffer: packs TDC measurements into sequenced event words, tracks drops, buffers in a FWFT FIFO.
module tdc_readout_buffer
    import tdc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     meas_valid,
    input  logic [3:0]               out_count,
    input  logic [1:0]               bin_out,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [SEQ_W+6:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               lost_cnt
);
    localparam int W = word_w(SEQ_W);
    logic full, empty, push, drop, pend;
    logic [SEQ_W-1:0] seq;
    logic [W-1:0] word;
    assign rd_valid = ~empty;
    assign push = meas_valid & (~full | rd_ready);
    assign drop = meas_valid & full & ~rd_ready;
    assign word = {pend, seq, out_count, bin_out};
    always_ff @(posedge clk) begin
        if (rst) begin
            seq <= '0;
            pend <= 1'b0;
            lost_cnt <= '0;
        end else if (push) begin
            seq <= seq + 1'b1;
            pend <= 1'b0;
        end else if (drop) begin
            pend <= 1'b1;
            lost_cnt <= lost_cnt + {7'd0, ~&lost_cnt};
        end
    end
    tdc_sync_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_ready),
        .din   (word),
        .dout  (rd_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );
endmodule
